// File: rtl/leddc_pkg.sv
// Shared types and defaults for the LED frame-buffer arbiter slice.
package leddc_pkg;

  localparam int AW_DEF    = 9;
  localparam int DW_DEF    = 16;
  localparam int PW_DEF    = 8;
  localparam int FRAME_PIX = 256;

  typedef enum logic {
    SHOWING = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_t;

endpackage

// File: rtl/frame_buf_arbiter_swap_ctrl.sv
// Double-buffer swap controller: tracks which buffer is displayed and whether a new frame waits.
// Optional FRAME_OVERRUN_CNT_EN adds a saturating count of frames overwritten before display.
module fb_swap_ctrl
  import leddc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       last_gnt,
  input  logic       frame_start,
  output logic       front_buf,
  output logic       frame_ready
`ifdef FRAME_OVERRUN_CNT_EN
  ,
  output logic [7:0] overrun_cnt
`endif
);

  swap_state_t state_q;
  swap_state_t state_d;
  logic        swap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SHOWING;
      front_buf <= 1'b0;
    end else begin
      state_q <= state_d;
      if (swap) front_buf <= ~front_buf;
    end
  end

  // A last word landing on the same cycle as frame_start completes the frame just in time to swap.
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    case (state_q)
      SHOWING: begin
        if (last_gnt) begin
          if (frame_start) swap = 1'b1;
          else             state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          swap    = 1'b1;
          state_d = SHOWING;
        end
      end
      default: state_d = SHOWING;
    endcase
  end

  always_comb begin
    frame_ready = (state_q == PENDING);
  end

`ifdef FRAME_OVERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_cnt <= 8'd0;
    end else if (last_gnt && (state_q == PENDING) && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: rtl/frame_buf_arbiter.sv
// Single-port frame SRAM arbiter: read-priority with write anti-starvation, double buffered.
// Optional FRAME_OVERRUN_CNT_EN exposes overrun_cnt from the swap controller.
module frame_buf_arbiter
  import leddc_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int PW            = PW_DEF,
  parameter int WR_STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [PW-1:0] wr_pix,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  output logic          wr_gnt,
  input  logic          rd_req,
  input  logic [PW-1:0] rd_pix,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          frame_start,
  output logic          front_buf,
  output logic          frame_ready,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  output logic          CEN,
  output logic          WEN,
  input  logic [DW-1:0] Q
`ifdef FRAME_OVERRUN_CNT_EN
  ,
  output logic [7:0]    overrun_cnt
`endif
);

  localparam int SW = $clog2(WR_STARVE_MAX + 1);

  gnt_t          gnt;
  logic [SW-1:0] starve;
  logic          starved;
  logic          rd_issued;
  logic [DW-1:0] rd_hold;

  assign starved = (starve == SW'(WR_STARVE_MAX));

  // Reads win unless the writer has waited long enough to force its turn.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (wr_req && (!rd_req || starved)) gnt = GNT_WR;
      else if (rd_req)                    gnt = GNT_RD;
    end
  end

  assign rd_gnt = (gnt == GNT_RD);
  assign wr_gnt = (gnt == GNT_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (!wr_req || wr_gnt) begin
      starve <= '0;
    end else if (!starved) begin
      starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A   <= '0;
      D   <= '0;
      CEN <= 1'b1;
      WEN <= 1'b1;
    end else begin
      case (gnt)
        GNT_RD: begin
          A   <= {front_buf, rd_pix};
          CEN <= 1'b0;
          WEN <= 1'b1;
        end
        GNT_WR: begin
          A   <= {~front_buf, wr_pix};
          D   <= wr_data;
          CEN <= 1'b0;
          WEN <= 1'b0;
        end
        default: begin
          CEN <= 1'b1;
          WEN <= 1'b1;
        end
      endcase
    end
  end

  // rd_data passes Q through in the valid cycle and otherwise replays the last word read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_issued <= 1'b0;
      rd_valid  <= 1'b0;
      rd_hold   <= '0;
    end else begin
      rd_issued <= (gnt == GNT_RD);
      rd_valid  <= rd_issued;
      if (rd_valid) rd_hold <= Q;
    end
  end

  assign rd_data = rd_valid ? Q : rd_hold;

  fb_swap_ctrl u_swap (
    .clk         (clk),
    .rst         (rst),
    .last_gnt    (wr_gnt && wr_last),
    .frame_start (frame_start),
    .front_buf   (front_buf),
    .frame_ready (frame_ready)
`ifdef FRAME_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Testbench for frame_buf_arbiter with a behavioural SRAM and a read-data scoreboard.
// Checks overrun_cnt when built with FRAME_OVERRUN_CNT_EN.
module tb_frame_buf_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, wr_last, wr_gnt;
  logic [7:0]  wr_pix;
  logic [15:0] wr_data;
  logic        rd_req, rd_gnt, rd_valid;
  logic [7:0]  rd_pix;
  logic [15:0] rd_data;
  logic        frame_start, front_buf, frame_ready;
  logic [8:0]  A;
  logic [15:0] D;
  logic        CEN, WEN;
  logic [15:0] Q = 16'h0;
`ifdef FRAME_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  always #5 clk = ~clk;

  frame_buf_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_pix(wr_pix), .wr_data(wr_data), .wr_last(wr_last), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_pix(rd_pix), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .frame_start(frame_start), .front_buf(front_buf), .frame_ready(frame_ready),
    .A(A), .D(D), .CEN(CEN), .WEN(WEN), .Q(Q)
`ifdef FRAME_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  logic [15:0] mem [512];
  logic [15:0] ref_mem [512];

  always @(posedge clk) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q <= mem[A];
    end
  end

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic        m_front;
  bit          m_pending;
  logic        c_rd_gnt, c_wr_gnt, c_rd_valid, c_CEN, c_WEN, c_front, c_ready;
  logic [8:0]  c_A;
  logic [15:0] c_D, c_rd_data;

  // Sample mid-cycle, track the bench's own buffer model, then advance past the next edge.
  task automatic cycle();
    bit last;
    @(negedge clk);
    c_rd_gnt = rd_gnt; c_wr_gnt = wr_gnt; c_rd_valid = rd_valid; c_rd_data = rd_data;
    c_CEN = CEN; c_WEN = WEN; c_A = A; c_D = D; c_front = front_buf; c_ready = frame_ready;
    if (c_rd_valid) obs_q.push_back(rd_data);
    if (c_rd_gnt) exp_q.push_back(ref_mem[{m_front, rd_pix}]);
    if (c_wr_gnt) ref_mem[{~m_front, wr_pix}] = wr_data;
    last = c_wr_gnt && wr_last;
    if (!m_pending) begin
      if (last && frame_start) m_front = ~m_front;
      else if (last)           m_pending = 1'b1;
    end else if (frame_start) begin
      m_front   = ~m_front;
      m_pending = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [7:0] id, input bit fs_last, output int missed);
    missed = 0;
    for (int p = 0; p < 256; p++) begin
      wr_req = 1'b1; wr_pix = p[7:0]; wr_data = {id, p[7:0]};
      wr_last = (p == 255); frame_start = fs_last && (p == 255);
      cycle();
      if (!c_wr_gnt) missed++;
      frame_start = 1'b0;
    end
    wr_req = 1'b0; wr_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_req = 1'b1; wr_req = 1'b1; rd_pix = 8'h3; wr_pix = 8'h4;
    wr_data = 16'hFFFF; wr_last = 1'b0; frame_start = 1'b0;
    m_front = 1'b0; m_pending = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rd_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_gnt: got %b expected 0", rd_gnt); end
    n_checks++; if (wr_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_gnt: got %b expected 0", wr_gnt); end
    n_checks++; if ({rd_valid, CEN, WEN, front_buf, frame_ready} !== 5'b01100)
      begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 01100", {rd_valid, CEN, WEN, front_buf, frame_ready}); end
    n_checks++; if ({A, D, rd_data} !== 41'h0)
      begin n_fail++; $display("[TB] FAIL reset_buses: got A=%h D=%h rd_data=%h expected zeros", A, D, rd_data); end
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    rd_req = 1'b1; rd_pix = 8'd5;
    cycle();
    n_checks++; if ({c_rd_gnt, c_wr_gnt} !== 2'b10) begin n_fail++; $display("[TB] FAIL read_gnt: got %b expected 10", {c_rd_gnt, c_wr_gnt}); end
    rd_req = 1'b0;
    cycle();
    n_checks++; if (c_A !== 9'h005) begin n_fail++; $display("[TB] FAIL read_addr: got %h expected 005", c_A); end
    n_checks++; if ({c_CEN, c_WEN, c_rd_valid} !== 3'b010) begin n_fail++; $display("[TB] FAIL read_pins: got %b expected 010", {c_CEN, c_WEN, c_rd_valid}); end
    cycle();
    n_checks++; if (c_rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL read_valid_lat2: got %b expected 1", c_rd_valid); end
    n_checks++; if (c_rd_data !== {7'h2A, 9'h005}) begin n_fail++; $display("[TB] FAIL read_data: got %h expected %h", c_rd_data, {7'h2A, 9'h005}); end
    cycle();
    n_checks++; if (c_rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL read_valid_pulse: got %b expected 0", c_rd_valid); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [15:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("[TB] FAIL read_sb: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_single_write();
    wr_req = 1'b1; wr_pix = 8'h10; wr_data = 16'hA5A5; wr_last = 1'b0;
    cycle();
    n_checks++; if ({c_rd_gnt, c_wr_gnt} !== 2'b01) begin n_fail++; $display("[TB] FAIL write_gnt: got %b expected 01", {c_rd_gnt, c_wr_gnt}); end
    wr_req = 1'b0;
    cycle();
    n_checks++; if (c_A !== 9'h110) begin n_fail++; $display("[TB] FAIL write_addr: got %h expected 110", c_A); end
    n_checks++; if (c_D !== 16'hA5A5) begin n_fail++; $display("[TB] FAIL write_data: got %h expected a5a5", c_D); end
    n_checks++; if ({c_CEN, c_WEN} !== 2'b00) begin n_fail++; $display("[TB] FAIL write_pins: got %b expected 00", {c_CEN, c_WEN}); end
    cycle();
    n_checks++; if ({c_CEN, c_WEN, c_A} !== {2'b11, 9'h110}) begin n_fail++; $display("[TB] FAIL idle_hold: got CEN/WEN=%b A=%h expected 11 110", {c_CEN, c_WEN}, c_A); end
  endtask

  // Two starvation windows back to back: the write must break through on cycles 4 and 9.
  task automatic test_starve();
    int k = 0;
    rd_req = 1'b1; wr_req = 1'b1; wr_pix = 8'h20; wr_data = 16'h1234; wr_last = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rd_pix = k[7:0];
      cycle();
      n_checks++;
      if ({c_rd_gnt, c_wr_gnt} !== ((i == 4 || i == 9) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("[TB] FAIL starve_cycle%0d: got %b expected %b", i, {c_rd_gnt, c_wr_gnt}, (i == 4 || i == 9) ? 2'b01 : 2'b10);
      end
      if (c_rd_gnt) k++;
      if (c_wr_gnt) begin wr_pix = wr_pix + 8'd1; wr_data = wr_data + 16'd1; end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (3) cycle();
    n_checks++; if (obs_q.size() !== 10) begin n_fail++; $display("[TB] FAIL starve_read_count: got %0d expected 10", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [15:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("[TB] FAIL starve_sb: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_frame_swap();
    int missed;
    logic [7:0] pix_list [3] = '{8'h10, 8'h80, 8'hFF};
    write_frame(8'h11, 1'b0, missed);
    n_checks++; if (missed !== 0) begin n_fail++; $display("[TB] FAIL frame1_grants: got %0d missed expected 0", missed); end
    cycle();
    n_checks++; if ({c_ready, c_front} !== 2'b10) begin n_fail++; $display("[TB] FAIL frame1_ready: got ready/front=%b expected 10", {c_ready, c_front}); end
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    cycle();
    n_checks++; if ({c_ready, c_front} !== 2'b01) begin n_fail++; $display("[TB] FAIL frame1_swap: got ready/front=%b expected 01", {c_ready, c_front}); end
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1; rd_pix = pix_list[i];
      cycle();
      rd_req = 1'b0;
      cycle();
      n_checks++; if (c_A !== {1'b1, pix_list[i]}) begin n_fail++; $display("[TB] FAIL frame1_rd_addr: got %h expected %h", c_A, {1'b1, pix_list[i]}); end
    end
    repeat (2) cycle();
    n_checks++; if (obs_q.size() !== 3) begin n_fail++; $display("[TB] FAIL frame1_read_count: got %0d expected 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [15:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("[TB] FAIL frame1_sb: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_simul_and_overrun();
    int missed;
    write_frame(8'h22, 1'b1, missed);
    cycle();
    n_checks++; if ({c_ready, c_front} !== 2'b00) begin n_fail++; $display("[TB] FAIL simul_swap: got ready/front=%b expected 00", {c_ready, c_front}); end
    write_frame(8'h33, 1'b0, missed);
    write_frame(8'h44, 1'b0, missed);
    cycle();
    n_checks++; if ({c_ready, c_front} !== 2'b10) begin n_fail++; $display("[TB] FAIL overrun_pending: got ready/front=%b expected 10", {c_ready, c_front}); end
`ifdef FRAME_OVERRUN_CNT_EN
    n_checks++; if (overrun_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL overrun_cnt: got %0d expected 1", overrun_cnt); end
`endif
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    cycle();
    n_checks++; if ({c_ready, c_front} !== 2'b01) begin n_fail++; $display("[TB] FAIL overrun_swap: got ready/front=%b expected 01", {c_ready, c_front}); end
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    cycle();
    n_checks++; if ({c_ready, c_front} !== 2'b01) begin n_fail++; $display("[TB] FAIL showing_no_swap: got ready/front=%b expected 01", {c_ready, c_front}); end
    rd_req = 1'b1; rd_pix = 8'h10;
    cycle();
    rd_req = 1'b0;
    repeat (3) cycle();
    n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("[TB] FAIL newest_read_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      logic [15:0] o;
      o = obs_q.pop_front();
      n_checks++; if (o !== 16'h4410) begin n_fail++; $display("[TB] FAIL newest_wins: got %h expected 4410", o); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    rd_req = 1'b1; rd_pix = 8'h3;
    cycle();
    rd_req = 1'b0;
    n_checks++; if (c_rd_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rd_gnt: got %b expected 1", c_rd_gnt); end
    #2 rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({rd_valid, CEN, WEN, front_buf, frame_ready, A, D} !== {5'b01100, 25'h0})
      begin n_fail++; $display("[TB] FAIL mid_reset_state: got %b A=%h D=%h expected 01100 0 0", {rd_valid, CEN, WEN, front_buf, frame_ready}, A, D); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_front = 1'b0; m_pending = 1'b0;
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
    repeat (3) cycle();
    n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("[TB] FAIL mid_discard: got %0d rd_valid pulses expected 0", obs_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = {7'h2A, i[8:0]};
      ref_mem[i] = {7'h2A, i[8:0]};
    end
    test_reset();
    test_single_read();
    test_single_write();
    test_starve();
    test_frame_swap();
    test_simul_and_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/frame_buf_arbiter.md
Name: frame_buf_arbiter

Overview:
Arbitrates a single-port 512x16 frame SRAM between two requesters: the pixel-ingress writer (deserialised 16-bit pixel words) and the scan/PWM reader. It manages double buffering. The SRAM holds two 256-pixel frames. The writer always fills the back buffer and the reader always scans the front buffer. Buffers swap only at a scan-frame boundary, after a complete frame has been written. It sits between the ingress/scan logic and the SRAM macro, all on one clock; requesters are already synchronised to clk.

Parameters:
AW, 9, SRAM address width; MSB is the buffer select.
DW, 16, pixel word width.
PW, 8, pixel index width within a frame (AW-1).
WR_STARVE_MAX, 4, consecutive denied write-request cycles before a write is forced.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
wr_req  in  1  writer requests an access; held with wr_pix/wr_data/wr_last until wr_gnt
wr_pix  in  PW  pixel index 0..255
wr_data  in  DW  pixel word
wr_last  in  1  this word completes a frame
wr_gnt  out  1  write accepted this cycle (combinational)
rd_req  in  1  reader requests a word; held with rd_pix until rd_gnt
rd_pix  in  PW  pixel index to read
rd_gnt  out  1  read accepted this cycle (combinational)
rd_valid  out  1  rd_data valid (registered pulse)
rd_data  out  DW  read word
frame_start  in  1  single-cycle pulse at the start of each scan frame
front_buf  out  1  buffer currently being displayed
frame_ready  out  1  complete back frame awaiting swap
A  out  AW  SRAM address (registered)
D  out  DW  SRAM write data (registered)
CEN  out  1  SRAM chip enable, active-low (registered)
WEN  out  1  SRAM write enable, active-low (registered)
Q  in  DW  SRAM read data, valid one cycle after CEN=0 with WEN=1

Behaviour:
- Reset values: wr_gnt=0, rd_gnt=0, rd_valid=0, rd_data=0, CEN=1, WEN=1, A=0, D=0, front_buf=0, frame_ready=0, starve counter=0, swap FSM=SHOWING.
- At most one grant per cycle. With no request, rd_gnt=wr_gnt=0.
- Reads have priority. A write is granted when rd_req=0, or when the starve counter has reached WR_STARVE_MAX.
- Starve counter: increments on each cycle where wr_req=1 and wr_gnt=0. It clears on wr_gnt or when wr_req=0, and saturates at WR_STARVE_MAX.
- Grant cycle N drives the registered SRAM pins in N+1:
  - Read: A={front_buf,rd_pix}, CEN=0, WEN=1.
  - Write: A={~front_buf,wr_pix}, D=wr_data, CEN=0, WEN=0.
  - Idle: CEN=1, WEN=1, A and D hold their values.
- Read latency: rd_valid=1 and rd_data=Q in cycle N+2, exactly 2 cycles after rd_gnt. rd_data holds its value otherwise.
- Back-to-back grants are allowed every cycle; reads pipeline at full rate.
- Swap FSM:
  - SHOWING -> PENDING on a write grant with wr_last=1; frame_ready=1.
  - PENDING -> SHOWING on frame_start: front_buf toggles and frame_ready=0.
  - frame_start in SHOWING: no swap.
- Simultaneous events:
  - frame_start and a wr_last grant in the same cycle: the swap happens in that cycle. That last word is addressed to the old back buffer, which becomes the new front, so the frame is complete.
  - A wr_last grant while already PENDING: stay PENDING. The newer frame overwrites the back buffer (newest wins).
- front_buf changes only at its register update. A read granted in the swap cycle uses the pre-swap front_buf; a read granted in the next cycle uses the new one.
- rst mid-operation: all state returns to reset values immediately; in-flight reads are discarded (no rd_valid).

Optional Feature:
FRAME_OVERRUN_CNT_EN
- Defined: adds output overrun_cnt[7:0], reset 0. It is a saturating count of wr_last grants taken while PENDING, i.e. frames overwritten before display.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package leddc_pkg holds:
  - the AW, DW and PW defaults;
  - the FRAME_PIX=256 constant;
  - a typedef for the swap state enum (SHOWING, PENDING);
  - a typedef for the grant enum (GNT_NONE, GNT_RD, GNT_WR).
- One sub-module, fb_swap_ctrl: the swap FSM, front_buf, frame_ready and the optional overrun counter. Arbitration and the SRAM pin registers stay in the top module.

Test Plan:
- Reset, then rd_req=1 rd_pix=5 with no write -> rd_gnt same cycle; A=0x005 CEN=0 WEN=1 next cycle; rd_valid=1 with rd_data=Q two cycles after the grant.
- Write only, wr_pix=0x10 wr_data=0xA5A5 -> wr_gnt same cycle; next cycle A=0x110, D=0xA5A5, WEN=0 (back buffer=1).
- rd_req and wr_req both held high for 8 cycles -> rd_gnt for 4 cycles, then wr_gnt in cycle 5; starve counter clears and reads resume.
- Write 256 words ending with wr_last, then frame_start -> frame_ready=1 after the last grant; front_buf 0->1 on frame_start; following reads address 0x1xx.
- frame_start in the same cycle as the wr_last grant -> immediate swap, frame_ready stays 0. A second full frame, then a third before frame_start -> one swap only; overrun_cnt=1 under FRAME_OVERRUN_CNT_EN.
- Assert rst between a rd_gnt and its rd_valid -> no rd_valid; all outputs at reset values; front_buf=0.
